// File: rtl/cia_bus_master.sv
// cia_bus_master: 6502-style PHI2 bus master driving a CIA with request/response handshake.
// Every output is registered from next-state and next-phase, so each output changes on the same edge as cnt.
module cia_bus_master #(
  parameter int HALF_PERIOD = 12,
  parameter int ADDR_DELAY  = 2,
  parameter int WDATA_DELAY = 4,
  parameter int RES_PERIODS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic       req_res,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       phi2,
  output logic       res_n,
  output logic       cs_n,
  output logic       r_w_n,
  output logic [3:0] addr_o,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  input  logic       irq_n,
  output logic       irq
);
  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam int PW = $clog2(RES_PERIODS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] C_H    = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] C_AD   = CW'(ADDR_DELAY);
  localparam logic [CW-1:0] C_WD   = CW'(HALF_PERIOD + WDATA_DELAY);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PW-1:0] R_LAST = PW'(RES_PERIODS - 1);

  typedef enum logic [2:0] {RESET, IDLE, PEND, LOW, HIGH, RESPULSE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_per;
  logic          r_we, r_res;
  logic [3:0]    r_addr;
  logic [7:0]    r_wdata, r_d1, r_d2;
  logic          r_i1, r_i2;
  logic          w_wrap, w_per_done, w_accept, w_cs, w_oe, w_in_res;

  assign w_cnt_nxt  = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
  assign w_wrap     = w_cnt_nxt == '0;
  assign w_per_done = w_wrap && r_per == R_LAST;
  assign w_accept   = req_valid && req_ready;
  assign w_in_res   = r_state == RESET || r_state == RESPULSE;
  // HIGH also covers cnt=0 of the following period, giving the hold time after PHI2 falls
  assign w_cs       = (w_next == LOW && w_cnt_nxt >= C_AD) || w_next == HIGH;
  assign w_oe       = w_next == HIGH && r_we && (w_cnt_nxt >= C_WD || w_wrap);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RESET:    w_next = w_per_done ? IDLE : RESET;
      IDLE:     w_next = !req_valid ? IDLE : !w_wrap ? PEND : req_res ? RESPULSE : LOW;
      PEND:     w_next = !w_wrap ? PEND : r_res ? RESPULSE : LOW;
      LOW:      w_next = (w_cnt_nxt == C_H) ? HIGH : LOW;
      HIGH:     w_next = (w_cnt_nxt == C_ONE) ? IDLE : HIGH;
      RESPULSE: w_next = w_per_done ? IDLE : RESPULSE;
      default:  w_next = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RESET;
      r_cnt     <= '0;
      r_per     <= '0;
      r_we      <= 1'b0;
      r_res     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_i1      <= 1'b1;
      r_i2      <= 1'b1;
      phi2      <= 1'b0;
      res_n     <= 1'b0;
      cs_n      <= 1'b1;
      r_w_n     <= 1'b1;
      addr_o    <= '0;
      data_o    <= '0;
      data_oe   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_per     <= w_wrap ? (w_in_res ? r_per + 1'b1 : '0) : r_per;
      r_we      <= w_accept ? req_we : r_we;
      r_res     <= w_accept ? req_res : r_res;
      r_addr    <= w_accept ? req_addr : r_addr;
      r_wdata   <= w_accept ? req_wdata : r_wdata;
      r_d1      <= data_i;
      r_d2      <= r_d1;
      r_i1      <= irq_n;
      r_i2      <= r_i1;
      phi2      <= w_cnt_nxt >= C_H;
      res_n     <= !(w_next == RESET || w_next == RESPULSE);
      cs_n      <= !w_cs;
      r_w_n     <= !(w_cs && r_we);
      addr_o    <= w_cs ? r_addr : addr_o;
      data_o    <= w_oe ? r_wdata : data_o;
      data_oe   <= w_oe;
      req_ready <= w_next == IDLE;
      rsp_valid <= w_next == IDLE && (r_state == HIGH || r_state == RESPULSE);
      rsp_rdata <= (r_state == HIGH && r_cnt == C_LAST && !r_we) ? r_d2 : rsp_rdata;
      irq       <= !r_i2;
    end
  end
endmodule

// File: tb/tb_cia_bus_master.sv
// tb_cia_bus_master: directed bench for cia_bus_master with default parameters (24 clk PHI2 period).
module tb_cia_bus_master;
  logic       clk = 0, rst = 0;
  logic       req_valid = 0, req_we = 0, req_res = 0;
  logic [3:0] req_addr = 0;
  logic [7:0] req_wdata = 0, data_i = 0;
  logic       irq_n = 1;
  logic       req_ready, rsp_valid, phi2, res_n, cs_n, r_w_n, data_oe, irq;
  logic [7:0] rsp_rdata, data_o;
  logic [3:0] addr_o;
  int         checks = 0, errors = 0;
  int         m_cnt = 0;

  cia_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_res(req_res), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .phi2(phi2), .res_n(res_n), .cs_n(cs_n), .r_w_n(r_w_n),
    .addr_o(addr_o), .data_o(data_o), .data_oe(data_oe), .data_i(data_i), .irq_n(irq_n), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) m_cnt <= rst ? 0 : (m_cnt == 23 ? 0 : m_cnt + 1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    do step(); while (m_cnt != v);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin step(); n++; end while (!rsp_valid && n < 200);
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({phi2, cs_n, r_w_n, res_n, req_ready, rsp_valid, data_oe, irq} !== 8'b0110_0000 ||
        addr_o !== 4'h0 || data_o !== 8'h00 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: phi2=%b cs_n=%b r_w_n=%b res_n=%b rdy=%b rv=%b oe=%b irq=%b addr=%h do=%h rd=%h, want 0 1 1 0 0 0 0 0 0 00 00",
               phi2, cs_n, r_w_n, res_n, req_ready, rsp_valid, data_oe, irq, addr_o, data_o, rsp_rdata);
    end
    for (int i = 1; i < 240; i++) begin
      step();
      checks++;
      if (res_n !== 1'b0 || req_ready !== 1'b0 || phi2 !== (m_cnt >= 12)) begin
        errors++;
        $display("FAIL reset_hold at clk %0d: res_n=%b rdy=%b phi2=%b, want 0 0 %b", i, res_n, req_ready, phi2, m_cnt >= 12);
      end
    end
    step();
    checks++;
    if (res_n !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || m_cnt != 0) begin
      errors++;
      $display("FAIL reset_release: res_n=%b rdy=%b rv=%b cnt=%0d, want 1 1 0 0", res_n, req_ready, rsp_valid, m_cnt);
    end
  endtask

  task automatic test_write();
    wait_cnt(5);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b want 1", req_ready); end
    req_valid = 1; req_we = 1; req_res = 0; req_addr = 4'h3; req_wdata = 8'hFF;
    step();
    req_valid = 0;
    wait_cnt(0);
    for (int t = 0; t <= 25; t++) begin
      logic ecs, eoe;
      if (t > 0) step();
      ecs = t >= 2 && t <= 24;
      eoe = t >= 16 && t <= 24;
      checks++;
      if (cs_n !== !ecs || r_w_n !== !ecs || data_oe !== eoe || rsp_valid !== (t == 25) ||
          (ecs && addr_o !== 4'h3) || (eoe && data_o !== 8'hFF)) begin
        errors++;
        $display("FAIL write_t%0d: cs_n=%b r_w_n=%b oe=%b rv=%b addr=%h do=%h, want %b %b %b %b 3 ff",
                 t, cs_n, r_w_n, data_oe, rsp_valid, addr_o, data_o, !ecs, !ecs, eoe, t == 25);
      end
    end
    checks++;
    if (req_ready !== 1'b1 || addr_o !== 4'h3) begin
      errors++;
      $display("FAIL write_end: rdy=%b addr=%h, want 1 3", req_ready, addr_o);
    end
  endtask

  task automatic test_read();
    data_i = 8'h81;
    wait_cnt(10);
    req_valid = 1; req_we = 0; req_addr = 4'hD;
    step();
    req_valid = 0;
    wait_cnt(0);
    for (int t = 0; t <= 25; t++) begin
      if (t > 0) step();
      checks++;
      if (cs_n !== !(t >= 2 && t <= 24) || r_w_n !== 1'b1 || data_oe !== 1'b0 || rsp_valid !== (t == 25) ||
          (t >= 2 && addr_o !== 4'hD)) begin
        errors++;
        $display("FAIL read_t%0d: cs_n=%b r_w_n=%b oe=%b rv=%b addr=%h", t, cs_n, r_w_n, data_oe, rsp_valid, addr_o);
      end
    end
    checks++;
    if (rsp_rdata !== 8'h81) begin errors++; $display("FAIL read_data: got %h want 81", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int n;
    data_i = 8'h5A;
    wait_cnt(1);
    req_valid = 1; req_we = 0; req_addr = 4'h5;
    step();
    req_valid = 0;
    wait_rsp(n);
    checks++;
    if (n != 47 || m_cnt != 1 || rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d cnt=%0d rd=%h, want 47 1 5a", n, m_cnt, rsp_rdata);
    end
    data_i = 8'h3C;
    req_valid = 1; req_addr = 4'h6;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    step();
    req_valid = 0;
    wait_rsp(n);
    checks++;
    if (n != 47 || m_cnt != 1 || rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d cnt=%0d rd=%h, want 47 1 3c", n, m_cnt, rsp_rdata);
    end
    data_i = 8'hC3;
    wait_cnt(23);
    req_valid = 1; req_addr = 4'h9;
    n = 0;
    do begin
      step();
      req_valid = 0;
      n++;
      if (n == 3) begin
        checks++;
        if (cs_n !== 1'b0 || addr_o !== 4'h9) begin
          errors++;
          $display("FAIL late_launch: cs_n=%b addr=%h at cnt=%0d, want 0 9", cs_n, addr_o, m_cnt);
        end
      end
    end while (!rsp_valid && n < 200);
    checks++;
    if (n != 26 || rsp_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL late_rsp: latency=%0d rd=%h, want 26 c3", n, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen_rv = 0;
    wait_cnt(3);
    req_valid = 1; req_we = 1; req_addr = 4'hA; req_wdata = 8'h55;
    step();
    req_valid = 0;
    wait_cnt(0);
    wait_cnt(18);
    checks++;
    if (data_oe !== 1'b1 || cs_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: oe=%b cs_n=%b, want 1 0", data_oe, cs_n);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (phi2 !== 1'b0 || cs_n !== 1'b1 || data_oe !== 1'b0 || res_n !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_edge: phi2=%b cs_n=%b oe=%b res_n=%b rv=%b, want 0 1 0 0 0", phi2, cs_n, data_oe, res_n, rsp_valid);
    end
    for (int i = 1; i < 240; i++) begin
      step();
      seen_rv |= rsp_valid | res_n | ~cs_n;
    end
    checks++;
    if (seen_rv) begin errors++; $display("FAIL midrst_hold: rv/res_n/cs activity seen=%b, want 0", seen_rv); end
    step();
    checks++;
    if (res_n !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: res_n=%b rdy=%b rv=%b, want 1 1 0", res_n, req_ready, rsp_valid);
    end
  endtask

  task automatic test_res_pulse();
    int bad = 0;
    int rv_count = 0;
    wait_cnt(7);
    req_valid = 1; req_res = 1; req_we = 1; req_addr = 4'h2;
    step();
    req_valid = 0; req_res = 0;
    wait_cnt(23);
    checks++;
    if (res_n !== 1'b1) begin errors++; $display("FAIL respulse_pre: res_n=%b want 1", res_n); end
    step();
    for (int t = 0; t < 240; t++) begin
      if (t > 0) step();
      if (res_n !== 1'b0 || cs_n !== 1'b1 || data_oe !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL respulse_hold: %0d bad clk, want 0", bad); end
    for (int t = 0; t < 30; t++) begin
      step();
      if (t == 0) begin
        checks++;
        if (res_n !== 1'b1 || rsp_valid !== 1'b1 || req_ready !== 1'b1 || m_cnt != 0) begin
          errors++;
          $display("FAIL respulse_end: res_n=%b rv=%b rdy=%b cnt=%0d, want 1 1 1 0", res_n, rsp_valid, req_ready, m_cnt);
        end
      end
      rv_count += int'(rsp_valid);
    end
    checks++;
    if (rv_count != 1) begin errors++; $display("FAIL respulse_single: %0d pulses, want 1", rv_count); end
  endtask

  task automatic test_irq();
    irq_n = 0;
    step(); step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_sync_delay: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
    irq_n = 1;
    step(); step(); step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_release: got %b want 0", irq); end
  endtask

  initial begin
    step();
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_write();
    test_res_pulse();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
